// File: rtl/systolic_array_sequencer.sv
`default_nettype none
// ============================================================================
// systolic_array_sequencer: schedules one N x N output-stationary matmul job
// Revision: 1.0
// ============================================================================
module systolic_array_sequencer #(
  parameter int N      = 4,
  parameter int AW     = 2,
  parameter int WARMUP = 3,
  parameter int PE_LAT = 4,
  parameter int DRAIN  = 2*N + PE_LAT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            a_rd_en,
  output logic [AW-1:0]   a_rd_addr,
  input  logic [N*32-1:0] a_rd_data,
  output logic            b_rd_en,
  output logic [AW-1:0]   b_rd_addr,
  input  logic [N*32-1:0] b_rd_data,
  output logic            array_rst_n,
  output logic [N*32-1:0] array_left,
  output logic [N*32-1:0] array_top,
  output logic [AW-1:0]   res_row_sel,
  output logic            res_we,
  output logic [AW-1:0]   res_addr
);

  localparam int CW = $clog2(WARMUP + N + DRAIN + 2);
  localparam logic [CW-1:0] C_WARM_LAST  = CW'(WARMUP - 1);
  localparam logic [CW-1:0] C_N_LAST     = CW'(N - 1);
  localparam logic [CW-1:0] C_DRAIN_LAST = CW'(DRAIN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_WARM  = 3'd2,
    S_FEED  = 3'd3,
    S_DRAIN = 3'd4,
    S_READ  = 3'd5,
    S_FIN   = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          clear_n_q, clear_n_d;
  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          res_we_q, res_we_d;
  logic [AW-1:0] res_addr_q, res_addr_d;
  logic          valid_q, valid_d;

  // Outputs are derived from the next state so that they are registered yet
  // line up with the state they describe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = (WARMUP == 0) ? S_FEED : S_WARM;
      end
      S_WARM: begin
        if (cnt_q == C_WARM_LAST) begin
          state_d = S_FEED;
          cnt_d   = '0;
        end
      end
      S_FEED: begin
        if (cnt_q == C_N_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        if (cnt_q == C_DRAIN_LAST) begin
          state_d = S_READ;
          cnt_d   = '0;
        end
      end
      S_READ: begin
        if (cnt_q == C_N_LAST) begin
          state_d = S_FIN;
          cnt_d   = '0;
        end
      end
      S_FIN: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d     = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d     = (state_d == S_FIN);
    clear_n_d  = (state_d != S_CLEAR);
    rd_en_d    = (state_d == S_FEED);
    rd_addr_d  = rd_en_d ? AW'(cnt_d) : '0;
    res_we_d   = (state_d == S_READ);
    res_addr_d = res_we_d ? AW'(cnt_d) : '0;
    valid_d    = rd_en_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      clear_n_q  <= 1'b1;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      res_we_q   <= 1'b0;
      res_addr_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      clear_n_q  <= clear_n_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      res_we_q   <= res_we_d;
      res_addr_q <= res_addr_d;
      valid_q    <= valid_d;
    end
  end

  // Lane i: one masking stage plus i delay stages gives the diagonal skew;
  // unfed cycles shift in exact zeros.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [31:0] a_pipe_d [0:i];
    logic [31:0] a_pipe_q [0:i];
    logic [31:0] b_pipe_d [0:i];
    logic [31:0] b_pipe_q [0:i];

    always_comb begin
      a_pipe_d[0] = valid_q ? a_rd_data[32*i +: 32] : 32'h0;
      b_pipe_d[0] = valid_q ? b_rd_data[32*i +: 32] : 32'h0;
      for (int s = 1; s <= i; s++) begin
        a_pipe_d[s] = a_pipe_q[s-1];
        b_pipe_d[s] = b_pipe_q[s-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= i; s++) begin
          a_pipe_q[s] <= 32'h0;
          b_pipe_q[s] <= 32'h0;
        end
      end else begin
        for (int s = 0; s <= i; s++) begin
          a_pipe_q[s] <= a_pipe_d[s];
          b_pipe_q[s] <= b_pipe_d[s];
        end
      end
    end

    assign array_left[32*i +: 32] = a_pipe_q[i];
    assign array_top[32*i +: 32]  = b_pipe_q[i];
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign a_rd_en     = rd_en_q;
  assign b_rd_en     = rd_en_q;
  assign a_rd_addr   = rd_addr_q;
  assign b_rd_addr   = rd_addr_q;
  assign array_rst_n = rst_n & clear_n_q;
  assign res_we      = res_we_q;
  assign res_addr    = res_addr_q;
  assign res_row_sel = res_addr_q;

endmodule
`default_nettype wire
